// File: rtl/vscale_src_a_seq_xvec.sv
// Operand-A source for the xvec datapath. On an input handshake it selects the
// full-width vector operand (rs1 lanes, PC, zero or rs1 lane-0 broadcast) and
// registers it. It then streams the operand to the beat-sliced vector ALU as
// NUM_LANES/LANES_PER_BEAT beats under valid/ready flow control.
module vscale_src_a_seq_xvec #(
    parameter int XPR_LEN        = 32,
    parameter int NUM_LANES      = 32,
    parameter int LANES_PER_BEAT = 8,
    parameter int SEL_WIDTH      = 2,
    localparam int NUM_BEATS     = NUM_LANES / LANES_PER_BEAT,
    localparam int IDX_W         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [SEL_WIDTH-1:0]                src_a_sel,
    input  logic [XPR_LEN-1:0]                  PC_DX,
    input  logic [NUM_LANES*XPR_LEN-1:0]        rs1_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LANES_PER_BEAT*XPR_LEN-1:0]   alu_src_a,
    output logic [IDX_W-1:0]                    out_beat_idx,
    output logic                                out_last,
    output logic                                busy
);

    localparam int OP_W   = NUM_LANES * XPR_LEN;
    localparam int BEAT_W = LANES_PER_BEAT * XPR_LEN;

    localparam logic [SEL_WIDTH-1:0] SEL_RS1   = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] SEL_PC    = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] SEL_ZERO  = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] SEL_BCAST = SEL_WIDTH'(3);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_BEATS - 1);
    localparam logic             SINGLE_BEAT = (NUM_BEATS == 1) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 state_r;
    logic [OP_W-1:0]        operand_r;
    logic [IDX_W-1:0]       beat_idx_r;
    logic                   out_valid_r;
    logic                   out_last_r;
    logic [BEAT_W-1:0]      alu_src_a_r;

    logic                   in_ready_s;
    logic                   accept_s;
    logic                   beat_hs_s;
    logic [IDX_W-1:0]       next_idx_s;
    logic [BEAT_W-1:0]      next_beat_s;
    logic [OP_W-1:0]        sel_operand_s;

    // Build the full-width operand for a given select; no lane arithmetic.
    function automatic logic [OP_W-1:0] select_operand(
        input logic [SEL_WIDTH-1:0] sel,
        input logic [XPR_LEN-1:0]   pc,
        input logic [OP_W-1:0]      rs1
    );
        logic [OP_W-1:0] op;
        op = {OP_W{1'b0}};
        case (sel)
            SEL_RS1:   op = rs1;
            SEL_PC:    op[XPR_LEN-1:0] = pc;
            SEL_ZERO:  op = {OP_W{1'b0}};
            SEL_BCAST: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    op[i*XPR_LEN +: XPR_LEN] = rs1[XPR_LEN-1:0];
                end
            end
            default:   op = {OP_W{1'b0}};
        endcase
        return op;
    endfunction

    // Input readiness: always free when idle, otherwise only as the last beat leaves.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_SEND: in_ready_s = out_ready && out_last_r;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Handshakes, operand selection and the slice for the following beat.
    always_comb begin
        accept_s      = in_valid && in_ready_s;
        beat_hs_s     = out_valid_r && out_ready;
        sel_operand_s = select_operand(src_a_sel, PC_DX, rs1_data);
        if (beat_idx_r == LAST_IDX) begin
            next_idx_s = {IDX_W{1'b0}};
        end else begin
            next_idx_s = beat_idx_r + IDX_W'(1);
        end
        next_beat_s = operand_r[int'(next_idx_s) * BEAT_W +: BEAT_W];
    end

    // Sequencer: capture on accept, advance on beat handshake, drop to idle after the last beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            operand_r   <= {OP_W{1'b0}};
            beat_idx_r  <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            alu_src_a_r <= {BEAT_W{1'b0}};
        end else if (accept_s) begin
            // Accept also covers the back-to-back case on the last beat handshake.
            state_r     <= ST_SEND;
            operand_r   <= sel_operand_s;
            beat_idx_r  <= {IDX_W{1'b0}};
            out_valid_r <= 1'b1;
            out_last_r  <= SINGLE_BEAT;
            alu_src_a_r <= sel_operand_s[BEAT_W-1:0];
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_SEND: begin
                    if (beat_hs_s) begin
                        if (out_last_r) begin
                            state_r     <= ST_IDLE;
                            beat_idx_r  <= {IDX_W{1'b0}};
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            alu_src_a_r <= {BEAT_W{1'b0}};
                        end else begin
                            beat_idx_r  <= next_idx_s;
                            out_last_r  <= (next_idx_s == LAST_IDX);
                            alu_src_a_r <= next_beat_s;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    beat_idx_r  <= {IDX_W{1'b0}};
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    alu_src_a_r <= {BEAT_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign busy         = out_valid_r;
    assign out_last     = out_last_r;
    assign out_beat_idx = beat_idx_r;
    assign alu_src_a    = alu_src_a_r;

endmodule

// File: doc/vscale_src_a_seq_xvec.md
Name: vscale_src_a_seq_xvec

Overview:
Registered, beat-serialising operand-A source for the xvec datapath. It selects the full-width vector operand A from rs1 lanes, PC, zero, or an rs1 lane-0 broadcast, and captures it on a valid/ready handshake. It then streams the operand to a narrower vector ALU as NUM_LANES/LANES_PER_BEAT beats. It sits between the DX-stage operand read and the beat-sliced vector ALU.

Parameters:
XPR_LEN, 32, bits per lane
NUM_LANES, 32, lanes in a full vector operand
LANES_PER_BEAT, 8, lanes delivered per output beat; must divide NUM_LANES (NUM_BEATS = NUM_LANES/LANES_PER_BEAT)
SEL_WIDTH, 2, width of src_a_sel

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  new operation request
in_ready  output  1  block can capture an operation this cycle
src_a_sel  input  SEL_WIDTH  0=RS1, 1=PC, 2=ZERO, 3=BCAST
PC_DX  input  XPR_LEN  program counter of the DX instruction
rs1_data  input  NUM_LANES*XPR_LEN  rs1 vector, lane i at bits [i*XPR_LEN +: XPR_LEN]
out_valid  output  1  alu_src_a holds a valid beat
out_ready  input  1  consumer accepts the current beat
alu_src_a  output  LANES_PER_BEAT*XPR_LEN  current beat's lanes
out_beat_idx  output  max(1,clog2(NUM_BEATS))  index of the current beat
out_last  output  1  current beat is beat NUM_BEATS-1
busy  output  1  operation held (equals out_valid)

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; out_valid=0, out_last=0, out_beat_idx=0, alu_src_a=0, busy=0; operand register cleared. Any in-flight operation is abandoned and no further beats are emitted. Reset has priority over every other event.
- States:
  - IDLE: in_ready=1.
  - SEND: in_ready = out_ready && out_last.
- Accept = in_valid && in_ready. On accept, the full operand is selected and registered:
  - RS1: lane i = rs1_data lane i.
  - PC: lane 0 = PC_DX, other lanes 0.
  - ZERO: all lanes 0.
  - BCAST: every lane = rs1_data lane 0.
  - Any encoding >3 (SEL_WIDTH>2): all lanes 0.
- Latency: beat 0 is presented with out_valid=1 in the cycle after accept. Inputs are don't-care when not accepted.
- Beat k drives lanes k*LANES_PER_BEAT .. k*LANES_PER_BEAT+LANES_PER_BEAT-1. Lane k*LANES_PER_BEAT is at alu_src_a bits [0 +: XPR_LEN].
- Beat handshake = out_valid && out_ready; on it, out_beat_idx increments.
- While out_valid && !out_ready, alu_src_a, out_beat_idx and out_last hold stable.
- Last-beat handshake:
  - If in_valid is high the same cycle, the new operation is captured and its beat 0 appears next cycle (back-to-back, no bubble).
  - Otherwise the block returns to IDLE, out_valid=0 and out_beat_idx=0.
- NUM_BEATS=1: every beat is last. The block is then a one-deep registered mux that accepts every cycle while out_ready=1.
- alu_src_a is 0 whenever out_valid=0.
- An all-ones PC_DX is passed unmodified; there is no arithmetic on any lane.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, alu_src_a=0, in_ready=1 after release; nothing captured during reset.
2. RS1 streaming, defaults, rs1_data lane i = 32'h100+i, out_ready=1 -> beats 0..3 on consecutive cycles starting 1 cycle after accept. Beat 2 lanes = 0x110..0x117; out_last only on beat 3.
3. PC select, PC_DX=32'h0000_2004 -> beat 0 lane 0 = 0x2004, all other lanes in all beats = 0. BCAST with lane 0 = 32'hDEAD_BEEF -> all 32 lanes = 0xDEADBEEF.
4. Backpressure: out_ready=0 for 3 cycles during beat 1 -> beat 1 data and out_beat_idx=1 held stable, in_ready=0; beat 2 follows the first out_ready=1 cycle.
5. Back-to-back: in_valid held high with a second RS1 op -> beat 0 of op 2 immediately follows beat 3 of op 1, with no idle cycle.
6. Mid-operation reset at beat 2 -> out_valid=0 the next cycle; the next accept restarts at beat 0 with the new operand. Repeat with LANES_PER_BEAT=32 (NUM_BEATS=1): one-cycle latency, full throughput.
